// File: rtl/time_of_day_counter_pkg.sv
// Shared types, digit limits and BCD increment helpers for the time-of-day counter.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } clk_mode_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t t;
    bcd_t u;
  } bcd_pair_t;

  localparam bcd_t SEC_T_MAX        = 4'd5;
  localparam bcd_t MIN_T_MAX        = 4'd5;
  localparam bcd_t HOUR_MAX_T       = 4'd2;
  localparam bcd_t HOUR_MAX_U_AT_T2 = 4'd3;
  localparam bcd_t BCD_MAX          = 4'd9;

  // Tens/units pair counting 00..(t_max)9, wrapping to 00.
  function automatic bcd_pair_t inc_base60(bcd_pair_t p, bcd_t t_max);
    bcd_pair_t r;
    r = p;
    if (p.u == BCD_MAX) begin
      r.u = '0;
      r.t = (p.t == t_max) ? '0 : p.t + 4'd1;
    end else begin
      r.u = p.u + 4'd1;
    end
    return r;
  endfunction

  function automatic logic is_base60_max(bcd_pair_t p, bcd_t t_max);
    return (p.t == t_max) && (p.u == BCD_MAX);
  endfunction

  function automatic bcd_pair_t inc_hour(bcd_pair_t p);
    bcd_pair_t r;
    r = p;
    if ((p.t == HOUR_MAX_T) && (p.u == HOUR_MAX_U_AT_T2)) begin
      r = '0;
    end else if (p.u == BCD_MAX) begin
      r.t = p.t + 4'd1;
      r.u = '0;
    end else begin
      r.u = p.u + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/time_of_day_counter_if.sv
// Button inputs and display-side outputs of the time-of-day counter.
interface time_of_day_counter_if;
  import clock_pkg::*;

  logic      _btn_mode;
  logic      _btn_inc;
  bcd_t      hour_t, hour_u, min_t, min_u, sec_t, sec_u;
  logic      _en_hour, _en_min, _en_sec;
  clk_mode_t mode;
  logic      tick;

  modport master (
    input  _btn_mode, _btn_inc,
    output hour_t, hour_u, min_t, min_u, sec_t, sec_u,
    output _en_hour, _en_min, _en_sec, mode, tick
  );

  modport slave (
    output _btn_mode, _btn_inc,
    input  hour_t, hour_u, min_t, min_u, sec_t, sec_u,
    input  _en_hour, _en_min, _en_sec, mode, tick
  );
endinterface

// File: rtl/time_of_day_counter_button_press.sv
// Two-flop synchroniser plus falling-edge detector producing a registered one-cycle press pulse.
module button_press (
  input  logic clk,
  input  logic _reset,
  input  logic _btn,
  output logic press
);

  // sync[1:0] is the synchroniser, sync[2] holds the previous synchronised level.
  logic [2:0] sync;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      sync  <= 3'b111;
      press <= 1'b0;
    end else begin
      sync  <= {sync[1:0], _btn};
      press <= sync[2] & ~sync[1];
    end
  end

endmodule

// File: rtl/time_of_day_counter.sv
// BCD hours:minutes:seconds counter with 1 Hz prescaler, two-button set mode and blinking digit enables.
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic                  clk,
  input  logic                  _reset,
  time_of_day_counter_if.master tod
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic mode_press, inc_press;

  button_press u_mode (.clk(clk), ._reset(_reset), ._btn(tod._btn_mode), .press(mode_press));
  button_press u_inc  (.clk(clk), ._reset(_reset), ._btn(tod._btn_inc),  .press(inc_press));

  clk_mode_t     state, next_state;
  logic [PW-1:0] presc, presc_n;
  logic [BW-1:0] blink_cnt, blink_cnt_n;
  logic          blink_phase, blink_phase_n;
  bcd_pair_t     hour, hour_n, min, min_n, sec, sec_n;
  logic          tick_q, tick_n;
  logic          en_hour_q, en_hour_n, en_min_q, en_min_n;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (mode_press) begin
      case (state)
        RUN:      next_state = SET_HOUR;
        SET_HOUR: next_state = SET_MIN;
        default:  next_state = RUN;
      endcase
    end
  end

  // A mode press takes priority: it clears the prescaler and suppresses both ticking and inc.
  always_comb begin
    presc_n       = presc;
    tick_n        = 1'b0;
    hour_n        = hour;
    min_n         = min;
    sec_n         = sec;
    blink_cnt_n   = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BW'(1);
    blink_phase_n = blink_phase ^ (blink_cnt == BLINK_LAST);
    if (mode_press) begin
      presc_n = '0;
      if (state == RUN) sec_n = '0;
    end else begin
      case (state)
        RUN: begin
          if (presc == PRESC_LAST) begin
            presc_n = '0;
            tick_n  = 1'b1;
            sec_n   = inc_base60(sec, SEC_T_MAX);
            if (is_base60_max(sec, SEC_T_MAX)) begin
              min_n = inc_base60(min, MIN_T_MAX);
              if (is_base60_max(min, MIN_T_MAX)) hour_n = inc_hour(hour);
            end
          end else begin
            presc_n = presc + PW'(1);
          end
        end
        SET_HOUR: if (inc_press) hour_n = inc_hour(hour);
        SET_MIN:  if (inc_press) min_n = inc_base60(min, MIN_T_MAX);
        default: ;
      endcase
    end
    en_hour_n = (next_state == SET_HOUR) & blink_phase_n;
    en_min_n  = (next_state == SET_MIN) & blink_phase_n;
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      presc       <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      hour        <= '0;
      min         <= '0;
      sec         <= '0;
      tick_q      <= 1'b0;
      en_hour_q   <= 1'b0;
      en_min_q    <= 1'b0;
    end else begin
      presc       <= presc_n;
      blink_cnt   <= blink_cnt_n;
      blink_phase <= blink_phase_n;
      hour        <= hour_n;
      min         <= min_n;
      sec         <= sec_n;
      tick_q      <= tick_n;
      en_hour_q   <= en_hour_n;
      en_min_q    <= en_min_n;
    end
  end

  assign tod.hour_t   = hour.t;
  assign tod.hour_u   = hour.u;
  assign tod.min_t    = min.t;
  assign tod.min_u    = min.u;
  assign tod.sec_t    = sec.t;
  assign tod.sec_u    = sec.u;
  assign tod._en_hour = en_hour_q;
  assign tod._en_min  = en_min_q;
  assign tod._en_sec  = 1'b0;
  assign tod.mode     = state;
  assign tod.tick     = tick_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed self-checking bench for time_of_day_counter with TICK_DIV=4, BLINK_DIV=2.
module tb_time_of_day_counter;
  import clock_pkg::*;

  logic clk = 1'b0;
  logic _reset;
  int   checks = 0;
  int   errors = 0;

  time_of_day_counter_if tod();

  time_of_day_counter #(.TICK_DIV(4), .BLINK_DIV(2)) dut (
    .clk    (clk),
    ._reset (_reset),
    .tod    (tod.master)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [23:0] current_time();
    return {tod.hour_t, tod.hour_u, tod.min_t, tod.min_u, tod.sec_t, tod.sec_u};
  endfunction

  function automatic logic [2:0] enables();
    return {tod._en_hour, tod._en_min, tod._en_sec};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_mode();
    tod._btn_mode = 1'b0;
    step(4);
    tod._btn_mode = 1'b1;
    step(3);
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      tod._btn_inc = 1'b0;
      step(4);
      tod._btn_inc = 1'b1;
      step(3);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (current_time() !== 24'h000000) begin
      errors++; $display("[TB] FAIL reset_time: got %h expected 000000", current_time());
    end
    checks++;
    if (tod.mode !== RUN || enables() !== 3'b000 || tod.tick !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl: got mode=%0d en=%b tick=%b expected 0 000 0", tod.mode, enables(), tod.tick);
    end
    _reset = 1'b1;
    step(3);
    checks++;
    if (tod.tick !== 1'b0) begin
      errors++; $display("[TB] FAIL early_tick: got %b expected 0", tod.tick);
    end
    step(1);
    checks++;
    if (tod.tick !== 1'b1 || current_time() !== 24'h000001) begin
      errors++; $display("[TB] FAIL first_tick: got tick=%b time=%h expected 1 000001", tod.tick, current_time());
    end
    press_inc(1);
    checks++;
    if (current_time()[23:8] !== 16'h0000 || tod.mode !== RUN) begin
      errors++; $display("[TB] FAIL run_inc_ignored: got hhmm=%h mode=%0d expected 0000 0", current_time()[23:8], tod.mode);
    end
  endtask

  task automatic test_set_hour();
    logic [5:0] s;
    logic       bad;
    press_mode();
    checks++;
    if (tod.mode !== SET_HOUR || current_time()[7:0] !== 8'h00) begin
      errors++; $display("[TB] FAIL enter_set_hour: got mode=%0d ss=%h expected 1 00", tod.mode, current_time()[7:0]);
    end
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s[i] = tod._en_hour;
      if (tod._en_min !== 1'b0 || tod._en_sec !== 1'b0) bad = 1'b1;
      step(1);
    end
    for (int i = 0; i < 4; i++) if (s[i+2] !== ~s[i]) bad = 1'b1;
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("[TB] FAIL hour_blink: got en_hour samples=%b expected phase toggling every 2 cycles, others 0", s);
    end
    press_inc(22);
    checks++;
    if (current_time()[23:16] !== 8'h22) begin
      errors++; $display("[TB] FAIL hour_to_22: got %h expected 22", current_time()[23:16]);
    end
    press_inc(1);
    checks++;
    if (current_time()[23:16] !== 8'h23) begin
      errors++; $display("[TB] FAIL hour_to_23: got %h expected 23", current_time()[23:16]);
    end
    press_inc(1);
    checks++;
    if (current_time()[23:16] !== 8'h00) begin
      errors++; $display("[TB] FAIL hour_wrap: got %h expected 00", current_time()[23:16]);
    end
    press_inc(23);
    checks++;
    if (current_time() !== 24'h230000) begin
      errors++; $display("[TB] FAIL hour_25_presses: got %h expected 230000", current_time());
    end
  endtask

  task automatic test_set_min();
    logic early;
    press_mode();
    checks++;
    if (tod.mode !== SET_MIN || tod._en_hour !== 1'b0 || current_time()[23:16] !== 8'h23) begin
      errors++; $display("[TB] FAIL enter_set_min: got mode=%0d en_hour=%b hh=%h expected 2 0 23", tod.mode, tod._en_hour, current_time()[23:16]);
    end
    press_inc(59);
    checks++;
    if (current_time() !== 24'h235900) begin
      errors++; $display("[TB] FAIL min_to_59: got %h expected 235900", current_time());
    end
    press_inc(1);
    checks++;
    if (current_time() !== 24'h230000) begin
      errors++; $display("[TB] FAIL min_wrap_no_carry: got %h expected 230000", current_time());
    end
    press_inc(59);
    tod._btn_mode = 1'b0;
    step(3);
    checks++;
    if (tod.mode !== SET_MIN) begin
      errors++; $display("[TB] FAIL exit_too_early: got mode=%0d expected 2", tod.mode);
    end
    step(1);
    checks++;
    if (tod.mode !== RUN || tod.tick !== 1'b0) begin
      errors++; $display("[TB] FAIL exit_to_run: got mode=%0d tick=%b expected 0 0", tod.mode, tod.tick);
    end
    tod._btn_mode = 1'b1;
    early = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (tod.tick !== 1'b0) early = 1'b1;
    end
    step(1);
    checks++;
    if (early !== 1'b0 || tod.tick !== 1'b1 || current_time() !== 24'h235901) begin
      errors++; $display("[TB] FAIL run_restart_tick: got early=%b tick=%b time=%h expected 0 1 235901", early, tod.tick, current_time());
    end
  endtask

  task automatic test_rollover();
    step(4 * 57);
    checks++;
    if (tod.tick !== 1'b1 || current_time() !== 24'h235958) begin
      errors++; $display("[TB] FAIL reach_235958: got tick=%b time=%h expected 1 235958", tod.tick, current_time());
    end
    step(1);
    checks++;
    if (tod.tick !== 1'b0) begin
      errors++; $display("[TB] FAIL tick_one_cycle: got %b expected 0", tod.tick);
    end
    step(3);
    checks++;
    if (tod.tick !== 1'b1 || current_time() !== 24'h235959) begin
      errors++; $display("[TB] FAIL reach_235959: got tick=%b time=%h expected 1 235959", tod.tick, current_time());
    end
    step(4);
    checks++;
    if (tod.tick !== 1'b1 || current_time() !== 24'h000000) begin
      errors++; $display("[TB] FAIL day_rollover: got tick=%b time=%h expected 1 000000", tod.tick, current_time());
    end
  endtask

  task automatic test_simultaneous();
    press_mode();
    press_inc(3);
    checks++;
    if (tod.mode !== SET_HOUR || current_time() !== 24'h030000) begin
      errors++; $display("[TB] FAIL hour_to_03: got mode=%0d time=%h expected 1 030000", tod.mode, current_time());
    end
    tod._btn_mode = 1'b0;
    tod._btn_inc  = 1'b0;
    step(4);
    tod._btn_mode = 1'b1;
    tod._btn_inc  = 1'b1;
    step(3);
    checks++;
    if (tod.mode !== SET_MIN || current_time() !== 24'h030000) begin
      errors++; $display("[TB] FAIL mode_beats_inc: got mode=%0d time=%h expected 2 030000", tod.mode, current_time());
    end
  endtask

  task automatic test_held_inc();
    tod._btn_inc = 1'b0;
    step(100);
    tod._btn_inc = 1'b1;
    step(3);
    checks++;
    if (current_time() !== 24'h030100) begin
      errors++; $display("[TB] FAIL held_inc: got %h expected 030100", current_time());
    end
  endtask

  task automatic test_latency();
    tod._btn_mode = 1'b0;
    step(3);
    checks++;
    if (tod.mode !== SET_MIN) begin
      errors++; $display("[TB] FAIL latency_early: got mode=%0d expected 2", tod.mode);
    end
    step(1);
    checks++;
    if (tod.mode !== RUN) begin
      errors++; $display("[TB] FAIL latency_n3: got mode=%0d expected 0", tod.mode);
    end
    tod._btn_mode = 1'b1;
    step(3);
  endtask

  task automatic test_reset_mid();
    press_mode();
    press_inc(9);
    press_mode();
    press_inc(33);
    checks++;
    if (tod.mode !== SET_MIN || current_time() !== 24'h123400) begin
      errors++; $display("[TB] FAIL preset_1234: got mode=%0d time=%h expected 2 123400", tod.mode, current_time());
    end
    #2;
    _reset = 1'b0;
    #1;
    checks++;
    if (current_time() !== 24'h000000 || tod.mode !== RUN || enables() !== 3'b000 || tod.tick !== 1'b0) begin
      errors++; $display("[TB] FAIL async_reset: got time=%h mode=%0d en=%b tick=%b expected 000000 0 000 0", current_time(), tod.mode, enables(), tod.tick);
    end
    step(2);
    _reset = 1'b1;
    step(4);
    checks++;
    if (tod.tick !== 1'b1 || current_time() !== 24'h000001 || tod.mode !== RUN) begin
      errors++; $display("[TB] FAIL post_reset_tick: got tick=%b time=%h mode=%0d expected 1 000001 0", tod.tick, current_time(), tod.mode);
    end
  endtask

  initial begin
    _reset        = 1'b0;
    tod._btn_mode = 1'b1;
    tod._btn_inc  = 1'b1;
    step(3);
    test_reset();
    test_set_hour();
    test_set_min();
    test_rollover();
    test_simultaneous();
    test_held_inc();
    test_latency();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
